// File: rtl/burst_phase_sequencer.sv
// Phase-accumulator sequencer driven by the burst controller's enable/reset levels.
// Optional BURST_CYCLE_COUNT_EN builds the saturating completed-cycle counter.
module burst_phase_sequencer #(
    parameter int ACC_W  = 48,
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 20
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              EN_Ctrl,
    input  logic              Reset_Ctrl,
    input  logic [ACC_W-1:0]  Freq_Word,
    input  logic [ADDR_W-1:0] Start_Phase,
    output logic [ADDR_W-1:0] Phase_Addr,
    output logic              Addr_Valid,
    output logic              Ctrl_Pulse,
    output logic [CNT_W-1:0]  Cycle_Count
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fw_q, fw_d;
    logic             pulse_q, pulse_d;
    logic [ACC_W-1:0] start_acc;
    logic [ACC_W:0]   sum;
    logic             wrap;

    assign start_acc = {Start_Phase, {(ACC_W-ADDR_W){1'b0}}};
    assign sum       = {1'b0, acc_q} + {1'b0, fw_q};
    // A carry only counts as a completed waveform cycle while the accumulator is live.
    assign wrap      = sum[ACC_W] && (state_q != IDLE) && !Reset_Ctrl;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fw_d    = fw_q;
        pulse_d = wrap;
        if (Reset_Ctrl) begin
            state_d = IDLE;
            acc_d   = start_acc;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_d = start_acc;
                    if (EN_Ctrl) begin
                        fw_d    = Freq_Word;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = sum[ACC_W-1:0];
                    if (!EN_Ctrl) state_d = FINISH;
                end
                FINISH: begin
                    acc_d = sum[ACC_W-1:0];
                    if (EN_Ctrl) begin
                        state_d = RUN;
                    end else if (sum[ACC_W]) begin
                        state_d = IDLE;
                        acc_d   = start_acc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = start_acc;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            acc_q   <= start_acc;
            fw_q    <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fw_q    <= fw_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef BURST_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Reset_Ctrl) begin
            cnt_d = '0;
        end else if (wrap && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Cycle_Count = cnt_q;
`else
    assign Cycle_Count = '0;
`endif

    assign Phase_Addr = acc_q[ACC_W-1 -: ADDR_W];
    assign Addr_Valid = (state_q != IDLE);
    assign Ctrl_Pulse = pulse_q;

endmodule

// File: tb/tb_burst_phase_sequencer.sv
// Directed bench for burst_phase_sequencer: per-cycle scoreboard fed by a reference model,
// plus directed checks of addresses, pulse totals and counter saturation (CNT_W=3 copy).
module tb_burst_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst, en, rc;
    logic [47:0] fw;
    logic [13:0] sp;

    logic [13:0] addr, addr3;
    logic        valid, valid3, pulse, pulse3;
    logic [19:0] cnt;
    logic [2:0]  cnt3;

    always #5 clk = ~clk;

    burst_phase_sequencer #(.ACC_W(48), .ADDR_W(14), .CNT_W(20)) dut (
        .Clock(clk), .Reset(rst), .EN_Ctrl(en), .Reset_Ctrl(rc),
        .Freq_Word(fw), .Start_Phase(sp),
        .Phase_Addr(addr), .Addr_Valid(valid), .Ctrl_Pulse(pulse), .Cycle_Count(cnt)
    );

    burst_phase_sequencer #(.ACC_W(48), .ADDR_W(14), .CNT_W(3)) dut3 (
        .Clock(clk), .Reset(rst), .EN_Ctrl(en), .Reset_Ctrl(rc),
        .Freq_Word(fw), .Start_Phase(sp),
        .Phase_Addr(addr3), .Addr_Valid(valid3), .Ctrl_Pulse(pulse3), .Cycle_Count(cnt3)
    );

`ifdef BURST_CYCLE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [13:0] addr;
        logic        valid;
        logic        pulse;
        logic [19:0] cnt;
        logic [2:0]  cnt3;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;

    // reference model: 0 idle, 1 run, 2 finish
    int          m_state = 0;
    logic [47:0] m_acc = '0;
    logic [47:0] m_fw = '0;
    logic        m_pulse = 1'b0;
    int          m_cnt = 0;
    int          m_cnt3 = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic e);
        logic [48:0] s;
        logic [47:0] start;
        start = {sp, 34'd0};
        s = {1'b0, m_acc} + {1'b0, m_fw};
        m_pulse = 1'b0;
        if (r || c) begin
            m_state = 0;
            m_acc = start;
            m_cnt = 0;
            m_cnt3 = 0;
            if (r) m_fw = '0;
        end else if (m_state == 0) begin
            m_acc = start;
            if (e) begin
                m_fw = fw;
                m_state = 1;
            end
        end else begin
            if (s[48]) begin
                m_pulse = 1'b1;
                if (m_cnt < 1048575) m_cnt++;
                if (m_cnt3 < 7) m_cnt3++;
            end
            m_acc = s[47:0];
            if (m_state == 1) begin
                if (!e) m_state = 2;
            end else if (e) begin
                m_state = 1;
            end else if (s[48]) begin
                m_state = 0;
                m_acc = start;
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic e);
        exp_t x, g;
        rst = r;
        rc  = c;
        en  = e;
        model_edge(r, c, e);
        x.addr  = m_acc[47:34];
        x.valid = (m_state != 0);
        x.pulse = m_pulse;
        x.cnt   = CNT_ON ? 20'(m_cnt) : 20'd0;
        x.cnt3  = CNT_ON ? 3'(m_cnt3) : 3'd0;
        q.push_back(x);
        @(posedge clk);
        #1;
        g = q.pop_front();
        check("sb_addr", 48'(addr), 48'(g.addr));
        check("sb_valid", 48'(valid), 48'(g.valid));
        check("sb_pulse", 48'(pulse), 48'(g.pulse));
        check("sb_cnt", 48'(cnt), 48'(g.cnt));
        check("sb_cnt3", 48'(cnt3), 48'(g.cnt3));
        if (pulse === 1'b1) pulses++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rc = 1'b0; en = 1'b0; fw = '0; sp = '0;
        step(1, 0, 0);
        step(1, 0, 0);
        check("rst_addr", 48'(addr), 48'h0);
        check("rst_valid", 48'(valid), 48'h0);
        check("rst_pulse", 48'(pulse), 48'h0);

        // start and wrap cadence
        fw = 48'h4000_0000_0000;
        step(0, 0, 1);
        check("start_valid", 48'(valid), 48'h1);
        check("start_addr", 48'(addr), 48'h0);
        step(0, 0, 1);
        check("inc1_addr", 48'(addr), 48'h1000);
        step(0, 0, 1);
        check("inc2_addr", 48'(addr), 48'h2000);
        step(0, 0, 1);
        check("inc3_addr", 48'(addr), 48'h3000);
        step(0, 0, 1);
        check("wrap_addr", 48'(addr), 48'h0);
        check("wrap_pulse", 48'(pulse), 48'h1);
        for (int i = 0; i < 16; i++) step(0, 0, 1);
        check("five_wraps_pulses", 48'(pulses), 48'd5);
        check("five_wraps_cnt", 48'(cnt), CNT_ON ? 48'd5 : 48'd0);

        // completion after enable drops
        step(0, 0, 1);
        check("pre_drop_addr", 48'(addr), 48'h1000);
        step(0, 0, 0);
        check("finish_addr", 48'(addr), 48'h2000);
        check("finish_valid", 48'(valid), 48'h1);
        step(0, 0, 0);
        step(0, 0, 0);
        check("final_pulse", 48'(pulse), 48'h1);
        check("final_valid", 48'(valid), 48'h0);
        check("final_addr", 48'(addr), 48'h0);
        step(0, 0, 0);
        check("idle_no_pulse", 48'(pulse), 48'h0);

        // re-enable during FINISH
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        check("reen_addr", 48'(addr), 48'h3000);
        check("reen_valid", 48'(valid), 48'h1);
        step(0, 0, 1);
        check("reen_cnt", 48'(cnt), CNT_ON ? 48'd7 : 48'd0);
        for (int i = 0; i < 12; i++) step(0, 0, 1);
        check("ten_pulses", 48'(pulses), 48'd10);
        check("ten_cnt", 48'(cnt), CNT_ON ? 48'd10 : 48'd0);
        check("sat_cnt3", 48'(cnt3), CNT_ON ? 48'd7 : 48'd0);
        check("sat_pulse3_addr", 48'(addr3), 48'(addr));

        // reset priority
        step(0, 0, 1);
        sp = 14'h0ABC;
        pulses = 0;
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        check("rc_valid", 48'(valid), 48'h0);
        check("rc_addr", 48'(addr), 48'h0ABC);
        check("rc_cnt", 48'(cnt), 48'h0);
        check("rc_no_pulse", 48'(pulses), 48'd0);
        step(0, 0, 1);
        check("rc_release_valid", 48'(valid), 48'h1);
        check("rc_release_addr", 48'(addr), 48'h0ABC);
        step(0, 0, 1);
        check("rc_release_inc", 48'(addr), 48'h1ABC);

        // zero frequency
        fw = '0;
        step(0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        check("zero_addr", 48'(addr), 48'h0ABC);
        check("zero_valid", 48'(valid), 48'h1);
        check("zero_pulses", 48'(pulses), 48'd0);
        step(0, 1, 0);
        check("zero_exit_valid", 48'(valid), 48'h0);

        // Freq_Word change during RUN is ignored
        fw = 48'h4000_0000_0000;
        sp = '0;
        step(0, 0, 1);
        fw = 48'h0100_0000_0000;
        step(0, 0, 1);
        step(0, 0, 1);
        check("fw_ignored_addr", 48'(addr), 48'h2000);

        // global reset mid-burst
        sp = 14'h0123;
        step(1, 0, 1);
        check("grst_valid", 48'(valid), 48'h0);
        check("grst_addr", 48'(addr), 48'h0123);
        check("grst_cnt", 48'(cnt), 48'h0);

        check("queue_drained", 48'(q.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
